// File: rtl/maze_timer_pkg.sv
// Shared definitions for the maze game timer: phase encoding, digit width,
// and the elaboration-time binary-to-BCD helper.
package maze_timer_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } game_state_e;

   // Packed as {hundreds, tens, units}.
   function automatic logic [3*DIGIT_W-1:0] to_bcd3(input int unsigned value);
      logic [DIGIT_W-1:0] hundreds;
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] units;
      hundreds = DIGIT_W'((value / 100) % 10);
      tens     = DIGIT_W'((value / 10) % 10);
      units    = DIGIT_W'(value % 10);
      return {hundreds, tens, units};
   endfunction

endpackage

// File: rtl/maze_timer_ctrl_bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and increment enable;
// wraps from 999 to 000.
module bcd_counter3
   import maze_timer_pkg::*;
(
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit0,
   output logic [DIGIT_W-1:0] digit1,
   output logic [DIGIT_W-1:0] digit2
);

   logic [DIGIT_W-1:0] d0_q, d0_d;
   logic [DIGIT_W-1:0] d1_q, d1_d;
   logic [DIGIT_W-1:0] d2_q, d2_d;

   always_comb begin
      d0_d = d0_q;
      d1_d = d1_q;
      d2_d = d2_q;
      if (clr) begin
         d0_d = '0;
         d1_d = '0;
         d2_d = '0;
      end else if (inc) begin
         if (d0_q == 4'd9) begin
            d0_d = '0;
            if (d1_q == 4'd9) begin
               d1_d = '0;
               d2_d = (d2_q == 4'd9) ? '0 : d2_q + 4'd1;
            end else begin
               d1_d = d1_q + 4'd1;
            end
         end else begin
            d0_d = d0_q + 4'd1;
         end
      end
   end

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         d0_q <= '0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         d0_q <= d0_d;
         d1_q <= d1_d;
         d2_q <= d2_d;
      end
   end

   assign digit0 = d0_q;
   assign digit1 = d1_q;
   assign digit2 = d2_q;

endmodule

// File: rtl/maze_timer_ctrl.sv
// Maze game timer sequencer: game phase FSM, one-second prescaler, BCD
// elapsed-time counter and end-of-game beep timer.
module maze_timer_ctrl
   import maze_timer_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int TICK_DIV        = CLOCK_FREQUENCY,
   parameter int TIME_LIMIT      = 100,
   parameter int BEEP_CYCLES     = 25000000
) (
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic               start,
   input  logic               pause,
   input  logic               goal_reached,
   output logic [DIGIT_W-1:0] digit0,
   output logic [DIGIT_W-1:0] digit1,
   output logic [DIGIT_W-1:0] digit2,
   output logic               tick,
   output logic [2:0]         game_state,
   output logic               beep
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BEEP_CYCLES + 1);
   // Comparing the pre-increment count lets LOSE be entered on the same edge
   // that the digits reach TIME_LIMIT.
   localparam logic [3*DIGIT_W-1:0] LIMIT_M1_BCD = to_bcd3(TIME_LIMIT - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LOAD  = BW'(BEEP_CYCLES);

   game_state_e     state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
   logic            beep_q, beep_d;
   logic            tick_q, tick_d;
   logic            clr, inc;

   bcd_counter3 u_count (
      .ClockIn (ClockIn),
      .Reset   (Reset),
      .clr     (clr),
      .inc     (inc),
      .digit0  (digit0),
      .digit1  (digit1),
      .digit2  (digit2)
   );

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      beep_cnt_d = beep_cnt_q;
      beep_d     = beep_q;
      tick_d     = 1'b0;
      clr        = 1'b0;
      inc        = 1'b0;

      if (beep_cnt_q != '0) begin
         beep_cnt_d = beep_cnt_q - BW'(1);
         beep_d     = (beep_cnt_q != BW'(1));
      end

      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (start) begin
               state_d = ST_RUN;
               clr     = 1'b1;
            end
         end
         ST_RUN: begin
            if (goal_reached) begin
               state_d    = ST_WIN;
               beep_cnt_d = BEEP_LOAD;
               beep_d     = 1'b1;
            end else begin
               if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  inc     = 1'b1;
                  tick_d  = 1'b1;
                  if ({digit2, digit1, digit0} == LIMIT_M1_BCD) begin
                     state_d    = ST_LOSE;
                     beep_cnt_d = BEEP_LOAD;
                     beep_d     = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               if (pause && state_d == ST_RUN) state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (start) begin
               state_d = ST_RUN;
               presc_d = '0;
               clr     = 1'b1;
            end else if (pause) begin
               state_d = ST_RUN;
            end
         end
         ST_WIN, ST_LOSE: begin
            presc_d = '0;
            if (start) begin
               state_d    = ST_RUN;
               clr        = 1'b1;
               beep_cnt_d = '0;
               beep_d     = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         beep_cnt_q <= '0;
         beep_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         beep_cnt_q <= beep_cnt_d;
         beep_q     <= beep_d;
         tick_q     <= tick_d;
      end
   end

   assign game_state = state_q;
   assign tick       = tick_q;
   assign beep       = beep_q;

endmodule

// File: tb/tb_maze_timer_ctrl.sv
// Self-checking bench for maze_timer_ctrl: directed scenarios followed by
// random pulses, all compared each cycle against an elapsed-seconds model.
module tb_maze_timer_ctrl;

   localparam int TICK_DIV    = 4;
   localparam int TIME_LIMIT  = 12;
   localparam int BEEP_CYCLES = 3;

   logic       ClockIn;
   logic       Reset;
   logic       start;
   logic       pause;
   logic       goal_reached;
   logic [3:0] digit0, digit1, digit2;
   logic       tick;
   logic [2:0] game_state;
   logic       beep;

   int vectors;
   int miscompares;

   // Reference model: phase, elapsed seconds as a plain integer, cycles into
   // the current second, and remaining beep cycles.
   int m_state;
   int m_sec;
   int m_pre;
   int m_beep;
   bit m_tick;

   maze_timer_ctrl #(
      .CLOCK_FREQUENCY (TICK_DIV),
      .TICK_DIV        (TICK_DIV),
      .TIME_LIMIT      (TIME_LIMIT),
      .BEEP_CYCLES     (BEEP_CYCLES)
   ) dut (
      .ClockIn      (ClockIn),
      .Reset        (Reset),
      .start        (start),
      .pause        (pause),
      .goal_reached (goal_reached),
      .digit0       (digit0),
      .digit1       (digit1),
      .digit2       (digit2),
      .tick         (tick),
      .game_state   (game_state),
      .beep         (beep)
   );

   initial ClockIn = 1'b0;
   always #5 ClockIn = ~ClockIn;

   task automatic chk(input string tag, input integer obs, input integer exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("state",  integer'(game_state), m_state);
      chk("digit0", integer'(digit0), m_sec % 10);
      chk("digit1", integer'(digit1), (m_sec / 10) % 10);
      chk("digit2", integer'(digit2), (m_sec / 100) % 10);
      chk("tick",   integer'(tick), integer'(m_tick));
      chk("beep",   integer'(beep), (m_beep > 0) ? 1 : 0);
   endtask

   task automatic model_reset();
      m_state = 0;
      m_sec   = 0;
      m_pre   = 0;
      m_beep  = 0;
      m_tick  = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit p, input bit g);
      m_tick = 1'b0;
      if (m_beep > 0) m_beep--;
      case (m_state)
         0: begin
            m_pre = 0;
            if (s) begin m_state = 1; m_sec = 0; end
         end
         1: begin
            if (g) begin
               m_state = 3;
               m_beep  = BEEP_CYCLES;
            end else begin
               if (m_pre == TICK_DIV - 1) begin
                  m_pre  = 0;
                  m_sec  = (m_sec + 1) % 1000;
                  m_tick = 1'b1;
                  if (m_sec == TIME_LIMIT) begin
                     m_state = 4;
                     m_beep  = BEEP_CYCLES;
                  end
               end else begin
                  m_pre++;
               end
               if (p && m_state == 1) m_state = 2;
            end
         end
         2: begin
            if (s) begin m_state = 1; m_sec = 0; m_pre = 0; end
            else if (p) m_state = 1;
         end
         default: begin
            m_pre = 0;
            if (s) begin m_state = 1; m_sec = 0; m_beep = 0; end
         end
      endcase
   endtask

   // Inputs are applied 1 ns after an edge, sampled on the next edge, and
   // outputs are checked 1 ns after that edge.
   task automatic step(input bit s, input bit p, input bit g);
      start        = s;
      pause        = p;
      goal_reached = g;
      @(posedge ClockIn);
      model_step(s, p, g);
      #1;
      start        = 1'b0;
      pause        = 1'b0;
      goal_reached = 1'b0;
      check_all();
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      start        = 1'b0;
      pause        = 1'b0;
      goal_reached = 1'b0;
      Reset        = 1'b1;
      model_reset();
      repeat (2) @(posedge ClockIn);
      #1;
      check_all();
      @(negedge ClockIn);
      Reset = 1'b0;
      @(posedge ClockIn);
      #1;
      check_all();

      // Start, first tick after four cycles, then run out the clock to LOSE.
      step(1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk("first_tick", integer'(tick), 1);
      for (int i = 0; i < 80 && m_state != 4; i++) step(0, 0, 0);
      chk("lose_state", integer'(game_state), 4);
      chk("lose_digits", integer'({digit2, digit1, digit0}), 12'h012);
      for (int i = 0; i < 6; i++) step(0, 0, 0);

      // Restart from LOSE, pause mid-second at 5 seconds, resume.
      step(1, 0, 0);
      for (int i = 0; i < 60 && !(m_sec == 5 && m_pre == 1); i++) step(0, 0, 0);
      step(0, 1, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1);
      chk("paused_digits", integer'({digit2, digit1, digit0}), 12'h005);
      step(0, 1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0);

      // Goal coinciding with the terminal prescaler count at 7 seconds.
      for (int i = 0; i < 60 && !(m_sec == 7 && m_pre == TICK_DIV - 1); i++) step(0, 0, 0);
      step(0, 0, 1);
      chk("win_digits", integer'({digit2, digit1, digit0}), 12'h007);
      step(0, 1, 1);

      // Restart from WIN mid-beep, then a start in RUN is ignored.
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);

      // Pause coinciding with a terminal tick still applies the increment.
      for (int i = 0; i < 60 && m_pre != TICK_DIV - 1; i++) step(0, 0, 0);
      step(0, 1, 0);
      step(1, 0, 0);

      // Asynchronous reset mid-count at 3 seconds.
      for (int i = 0; i < 60 && !(m_sec == 3 && m_pre == 1); i++) step(0, 0, 0);
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge ClockIn);
      #1;
      check_all();
      @(negedge ClockIn);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 0);

      // Random pulses against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 29) == 0),
              ($urandom_range(0, 14) == 0),
              ($urandom_range(0, 39) == 0));
         if (m_state == 0) step(1, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
